// File: rtl/mux_scan.sv
`default_nettype none
// ============================================================================
// Module   : mux_scan
// Purpose  : Registered N_CH-channel, DW-bit multiplexer with two selection
//            modes. Manual mode loads the channel from sel_in. Scan mode steps
//            through all channels, holding each for dwell+1 cycles. Output
//            data and channel index are registered in the same edge, so they
//            always agree.
// Ports    : clk        - system clock, rising edge
//            rst_n      - asynchronous active-low reset
//            din        - packed channel data, channel k = din[k*DW +: DW]
//            mode       - 0 = manual, 1 = scan
//            sel_in     - channel to load
//            sel_load   - load sel_in this cycle
//            dwell      - cycles-minus-one each channel is held in scan mode
//            hold       - freeze channel index and dwell counter
//            dout       - registered data of channel sel_out
//            sel_out    - registered current channel index
//            dout_valid - high once dout holds sampled data
//            wrap       - one-cycle pulse on scan advance N_CH-1 -> 0
//            sel_err    - one-cycle pulse on a load with sel_in >= N_CH
// Revision : 1.0 - initial release
// ============================================================================
module mux_scan #(
   parameter int N_CH    = 8,
   parameter int DW      = 4,
   parameter int SEL_W   = $clog2(N_CH),
   parameter int DWELL_W = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N_CH*DW-1:0]   din,
   input  logic                 mode,
   input  logic [SEL_W-1:0]     sel_in,
   input  logic                 sel_load,
   input  logic [DWELL_W-1:0]   dwell,
   input  logic                 hold,
   output logic [DW-1:0]        dout,
   output logic [SEL_W-1:0]     sel_out,
   output logic                 dout_valid,
   output logic                 wrap,
   output logic                 sel_err
);

   // One extra bit so the range check also works when N_CH == 2**SEL_W.
   localparam logic [SEL_W:0]   c_n_ch = (SEL_W+1)'(N_CH);
   localparam logic [SEL_W-1:0] c_last = SEL_W'(N_CH - 1);

   logic [SEL_W-1:0]   r_sel;
   logic [DWELL_W-1:0] r_cnt;
   logic               r_mode;

   logic [SEL_W-1:0]   w_sel_next;
   logic [DWELL_W-1:0] w_cnt_next;
   logic               w_mode_next;
   logic               w_wrap_next;
   logic               w_err_next;
   logic               w_sel_in_ok;
   logic [DW-1:0]      w_dout_next;
   logic [DW-1:0]      w_ch [N_CH];

   for (genvar k = 0; k < N_CH; k++) begin : g_ch
      assign w_ch[k] = din[k*DW +: DW];
   end

   assign w_sel_in_ok = ({1'b0, sel_in} < c_n_ch);

   // Next channel / counter. Priority: hold > sel_load > mode change > scan.
   always_comb begin
      w_sel_next  = r_sel;
      w_cnt_next  = r_cnt;
      w_mode_next = r_mode;
      w_wrap_next = 1'b0;
      w_err_next  = 1'b0;
      if (!hold) begin
         // The mode register only follows while not holding, so a mode change
         // made under hold is still seen once hold releases.
         w_mode_next = mode;
         if (sel_load) begin
            if (w_sel_in_ok) begin
               w_sel_next = sel_in;
               w_cnt_next = '0;
            end else begin
               w_err_next = 1'b1;
            end
         end else if (mode != r_mode) begin
            // Keep the channel, restart with a full dwell.
            w_cnt_next = '0;
         end else if (!mode) begin
            w_cnt_next = '0;
         end else if (r_cnt == dwell) begin
            w_cnt_next = '0;
            if (r_sel == c_last) begin
               w_sel_next  = '0;
               w_wrap_next = 1'b1;
            end else begin
               w_sel_next = r_sel + 1'b1;
            end
         end else begin
            // Wraps through 2**DWELL_W if dwell was lowered below r_cnt.
            w_cnt_next = r_cnt + 1'b1;
         end
      end
   end

   // Data of the channel that will be current after this edge.
   always_comb begin
      w_dout_next = '0;
      for (int k = 0; k < N_CH; k++) begin
         if (w_sel_next == SEL_W'(k)) begin
            w_dout_next = w_ch[k];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sel      <= '0;
         r_cnt      <= '0;
         r_mode     <= 1'b0;
         dout       <= '0;
         dout_valid <= 1'b0;
         wrap       <= 1'b0;
         sel_err    <= 1'b0;
      end else begin
         r_sel      <= w_sel_next;
         r_cnt      <= w_cnt_next;
         r_mode     <= w_mode_next;
         dout       <= w_dout_next;
         dout_valid <= 1'b1;
         wrap       <= w_wrap_next;
         sel_err    <= w_err_next;
      end
   end

   assign sel_out = r_sel;

endmodule
`default_nettype wire

// File: tb/tb_mux_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_scan
// Purpose  : Self-checking bench for mux_scan. An 8-channel and a 5-channel
//            instance are driven with directed steps; expected outputs are
//            queued when a step is driven and compared after the edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux_scan;

   typedef struct {
      logic [3:0] sel;
      logic [3:0] dout;
      logic       wrap;
      logic       err;
   } exp_t;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b1;

   logic [31:0] din8;
   logic        mode8, sel_load8, hold8;
   logic [2:0]  sel_in8;
   logic [7:0]  dwell8;
   logic [3:0]  dout8;
   logic [2:0]  sel_out8;
   logic        valid8, wrap8, err8;

   logic [19:0] din5;
   logic        mode5, sel_load5, hold5;
   logic [2:0]  sel_in5;
   logic [7:0]  dwell5;
   logic [3:0]  dout5;
   logic [2:0]  sel_out5;
   logic        valid5, wrap5, err5;

   exp_t q8[$];
   exp_t q5[$];
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   mux_scan #(.N_CH(8), .DW(4), .SEL_W(3), .DWELL_W(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .din(din8), .mode(mode8), .sel_in(sel_in8),
      .sel_load(sel_load8), .dwell(dwell8), .hold(hold8), .dout(dout8),
      .sel_out(sel_out8), .dout_valid(valid8), .wrap(wrap8), .sel_err(err8)
   );

   mux_scan #(.N_CH(5), .DW(4), .SEL_W(3), .DWELL_W(8)) u_dut5 (
      .clk(clk), .rst_n(rst_n), .din(din5), .mode(mode5), .sel_in(sel_in5),
      .sel_load(sel_load5), .dwell(dwell5), .hold(hold5), .dout(dout5),
      .sel_out(sel_out5), .dout_valid(valid5), .wrap(wrap5), .sel_err(err5)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push8(input int sel, input int dout, input bit wr, input bit er);
      exp_t e;
      e.sel = 4'(sel); e.dout = 4'(dout); e.wrap = wr; e.err = er;
      q8.push_back(e);
   endtask

   task automatic push5(input int sel, input int dout, input bit wr, input bit er);
      exp_t e;
      e.sel = 4'(sel); e.dout = 4'(dout); e.wrap = wr; e.err = er;
      q5.push_back(e);
   endtask

   // Advance one edge and compare whatever was queued for it.
   task automatic tick();
      exp_t e;
      @(posedge clk);
      #1;
      if (q8.size() > 0) begin
         e = q8.pop_front();
         chk("sel_out8", {29'd0, sel_out8}, {28'd0, e.sel});
         chk("dout8",    {28'd0, dout8},    {28'd0, e.dout});
         chk("wrap8",    {31'd0, wrap8},    {31'd0, e.wrap});
         chk("sel_err8", {31'd0, err8},     {31'd0, e.err});
         chk("valid8",   {31'd0, valid8},   32'd1);
      end
      if (q5.size() > 0) begin
         e = q5.pop_front();
         chk("sel_out5", {29'd0, sel_out5}, {28'd0, e.sel});
         chk("dout5",    {28'd0, dout5},    {28'd0, e.dout});
         chk("wrap5",    {31'd0, wrap5},    {31'd0, e.wrap});
         chk("sel_err5", {31'd0, err5},     {31'd0, e.err});
         chk("valid5",   {31'd0, valid5},   32'd1);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_dout8"},  {28'd0, dout8},    32'd0);
      chk({tag, "_sel8"},   {29'd0, sel_out8}, 32'd0);
      chk({tag, "_valid8"}, {31'd0, valid8},   32'd0);
      chk({tag, "_wrap8"},  {31'd0, wrap8},    32'd0);
      chk({tag, "_err8"},   {31'd0, err8},     32'd0);
      chk({tag, "_dout5"},  {28'd0, dout5},    32'd0);
      chk({tag, "_sel5"},   {29'd0, sel_out5}, 32'd0);
      chk({tag, "_valid5"}, {31'd0, valid5},   32'd0);
   endtask

   initial begin
      for (int k = 0; k < 8; k++) din8[k*4 +: 4] = 4'(k + 1);
      for (int k = 0; k < 5; k++) din5[k*4 +: 4] = 4'(k + 10);
      mode8 = 0; sel_load8 = 0; hold8 = 0; sel_in8 = 0; dwell8 = 0;
      mode5 = 0; sel_load5 = 0; hold5 = 0; sel_in5 = 0; dwell5 = 0;

      // Power-on reset
      #1 rst_n = 1'b0;
      #3 chk_reset("por");
      @(negedge clk) rst_n = 1'b1;

      // Manual sweep: load 0..7
      for (int i = 0; i < 8; i++) begin
         sel_load8 = 1; sel_in8 = 3'(i);
         push8(i, i + 1, 0, 0);
         tick();
      end
      sel_load8 = 0;

      // Fresh reset, then scan with dwell=2
      #2 rst_n = 1'b0;
      #1 chk_reset("rst2");
      @(negedge clk) rst_n = 1'b1;
      push8(0, 1, 0, 0);
      tick();
      mode8 = 1; dwell8 = 8'd2;
      for (int e = 1; e <= 25; e++) begin
         push8(((e - 1) / 3) % 8, ((e - 1) / 3) % 8 + 1, e == 25, 0);
         tick();
      end

      // dwell=0: new channel every cycle
      dwell8 = 8'd0;
      for (int e = 1; e <= 9; e++) begin
         push8(e % 8, e % 8 + 1, e == 8, 0);
         tick();
      end

      // Scan to channel 3 with dwell=2, then hold there
      dwell8 = 8'd2;
      push8(1, 2, 0, 0); tick();
      push8(1, 2, 0, 0); tick();
      push8(2, 3, 0, 0); tick();
      push8(2, 3, 0, 0); tick();
      push8(2, 3, 0, 0); tick();
      push8(3, 4, 0, 0); tick();
      push8(3, 4, 0, 0); tick();
      hold8 = 1;
      push8(3, 4, 0, 0); tick();
      din8[15:12] = 4'd9;
      for (int h = 0; h < 4; h++) begin
         push8(3, 9, 0, 0);
         tick();
      end
      hold8 = 0;
      push8(3, 9, 0, 0); tick();
      push8(4, 5, 0, 0); tick();
      din8[15:12] = 4'd4;

      // Priority: hold beats load
      hold8 = 1; sel_load8 = 1; sel_in8 = 3'd6;
      push8(4, 5, 0, 0); tick();
      hold8 = 0; sel_load8 = 0;
      push8(4, 5, 0, 0); tick();
      push8(4, 5, 0, 0); tick();
      // Load at the dwell boundary wins over the advance and restarts dwell
      sel_load8 = 1; sel_in8 = 3'd5;
      push8(5, 6, 0, 0); tick();
      sel_load8 = 0;
      push8(5, 6, 0, 0); tick();
      push8(5, 6, 0, 0); tick();
      push8(6, 7, 0, 0); tick();
      push8(6, 7, 0, 0); tick();

      // Reset mid-scan on channel 6: asynchronous clear
      #2 rst_n = 1'b0;
      #1 chk_reset("midscan");
      @(negedge clk) rst_n = 1'b1;
      push8(0, 1, 0, 0); tick();
      push8(0, 1, 0, 0); tick();
      push8(0, 1, 0, 0); tick();
      push8(1, 2, 0, 0); tick();

      // Five-channel instance: range error and wrap 4->0
      sel_load5 = 1; sel_in5 = 3'd2;
      push5(2, 12, 0, 0); tick();
      sel_in5 = 3'd6;
      push5(2, 12, 0, 1); tick();
      sel_load5 = 0;
      push5(2, 12, 0, 0); tick();
      sel_load5 = 1; sel_in5 = 3'd5;
      push5(2, 12, 0, 1); tick();
      sel_load5 = 0; mode5 = 1; dwell5 = 8'd0;
      push5(2, 12, 0, 0); tick();
      push5(3, 13, 0, 0); tick();
      push5(4, 14, 0, 0); tick();
      push5(0, 10, 1, 0); tick();
      push5(1, 11, 0, 0); tick();

      chk("q8_drained", q8.size(), 32'd0);
      chk("q5_drained", q5.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mux_scan.md
# mux_scan

Parametrised, registered N-channel, W-bit multiplexer with two selection modes. In manual mode, the channel is loaded from an input. In scan mode, the block steps through all channels automatically, holding each one for a programmable dwell time. It replaces the fixed combinational 8:1 single-bit mux in lab datapaths that need a clocked channel scanner, for example display multiplexing or sensor round-robin. Output data and the current channel index are registered together, so they are always consistent.

## Interface
- N_CH, 8, number of input channels (≥2, need not be a power of 2)
- DW, 4, data width per channel
- SEL_W, $clog2(N_CH), select/index width
- DWELL_W, 8, dwell counter width
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- din  in  N_CH*DW  packed channel data; channel k = din[k*DW +: DW]
- mode  in  1  0 = manual, 1 = scan
- sel_in  in  SEL_W  channel to load
- sel_load  in  1  load sel_in this cycle (level-sampled each cycle)
- dwell  in  DWELL_W  cycles-minus-one each channel is held in scan mode
- hold  in  1  freeze channel index and dwell counter
- dout  out  DW  registered data of channel sel_out
- sel_out  out  SEL_W  registered current channel index
- dout_valid  out  1  high once dout holds sampled data
- wrap  out  1  one-cycle pulse when scan advances N_CH-1 -> 0
- sel_err  out  1  one-cycle pulse when sel_load carries sel_in ≥ N_CH

## Operation
- Internal state: sel (SEL_W), cnt (DWELL_W).
- Each edge computes sel_next. Then sel_out <= sel_next and dout <= din[sel_next] in the same edge.
- Priority per cycle is hold > sel_load > scan advance.
- hold=1:
  - sel and cnt are unchanged.
  - dout still resamples din[sel], so it tracks live data.
  - sel_load is ignored and no sel_err is raised.
- sel_load=1, sel_in < N_CH:
  - sel_next = sel_in and cnt <= 0.
  - Valid in both modes; in scan mode, scanning restarts from sel_in.
- sel_load=1, sel_in ≥ N_CH:
  - sel and cnt are unchanged.
  - sel_err=1 for one cycle.
- Manual mode, no load: sel is unchanged and cnt stays 0.
- Scan mode, no load, no hold:
  - If cnt == dwell: cnt <= 0 and sel advances.
    - If sel == N_CH-1, sel_next = 0 and wrap=1 for one cycle.
    - Otherwise sel_next = sel+1.
  - Otherwise cnt <= cnt+1.
  - dwell=0 advances every cycle; dwell=D holds each channel D+1 cycles.
- dwell changed mid-scan: takes effect on the next comparison. If cnt > new dwell, cnt keeps counting and wraps through 2^DWELL_W before matching; no special handling.
- Mode change (either direction): cnt <= 0 and sel is retained. Scan resumes from the current channel with a full dwell.
- dout_valid: 0 in reset, 1 from the first rising edge after rst_n deasserts, then stays 1.

## Timing
- Reset (rst_n=0, asynchronous): dout=0, sel_out=0, dout_valid=0, wrap=0, sel_err=0, sel=0, cnt=0.
- Latency is 1 cycle. sel_load at cycle t gives sel_out=sel_in and dout=din[sel_in] after edge t.
- A din change on the selected channel appears on dout 1 cycle later.
- wrap and sel_err are registered and asserted in the same cycle as the sel_out update they describe.
- Reset asserted mid-scan clears all state immediately. After release, scan starts at channel 0 with a full dwell.

## Test plan
- Manual sweep, N_CH=8, DW=4, din[k]=k+1: sel_load with sel_in=0..7 -> one cycle later dout=1..8 and sel_out=0..7; sel_err stays 0.
- Scan with dwell=2 from reset -> sel_out holds each of 0,1,…,7 for 3 cycles each, then 0; wrap pulses once, on the 7->0 edge; dwell=0 gives a channel change every cycle.
- hold asserted for 5 cycles mid-scan on channel 3 while din[3] changes from 4 to 9 -> sel_out stays 3 and dout follows to 9; after release, the remaining dwell resumes.
- Priority: hold=1 with sel_load=1 -> no change. sel_load=1 with sel_in=5 in scan mode at the dwell boundary -> sel_out=5 with cnt restarted, no advance, no wrap.
- N_CH=5: sel_load with sel_in=6 -> sel_err pulse and sel_out unchanged. In scan mode -> wrap on 4->0.
- Reset mid-scan at channel 6 -> all outputs 0 asynchronously. dout_valid rises on the first edge after release, and the scan restarts at 0.
